// File: rtl/progloader_if.sv
// Byte-stream handshake and program-memory write bus for the program loader.
// master: the loader side (accepts bytes, drives the memory write port).
// slave:  the environment side (supplies bytes, observes memory writes).
interface progloader_if #(
  parameter int WORDSIZE = 64
) ();
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                mem_we;
  logic [WORDSIZE-1:0] mem_addr;
  logic [31:0]         mem_wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/progloader.sv
// Program loader: receives a 16-bit little-endian instruction count followed by
// count little-endian 32-bit instructions over a byte stream, writes each
// instruction to program memory at byte address 4*index, and holds the core in
// reset until the whole program has been loaded.
module progloader #(
  parameter int DEPTH    = 256,
  parameter int WORDSIZE = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  progloader_if.master   bus,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic           cpu_hold
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    LOAD  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  // Count is checked with one extra bit so DEPTH itself (e.g. 65536) stays representable.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t              state_r;
  state_t              state_next;
  logic [15:0]         count_r;
  logic [15:0]         index_r;
  logic [1:0]          pos_r;
  logic [31:0]         word_r;
  logic                in_ready_r;
  logic                mem_we_r;
  logic [WORDSIZE-1:0] mem_addr_r;
  logic [31:0]         mem_wdata_r;
  logic                busy_r;
  logic                done_r;
  logic                error_r;
  logic                cpu_hold_r;

  logic                accept_s;
  logic [15:0]         hdr_count_s;
  logic                hdr_bad_s;

  // A byte moves only when the loader is ready (registered from state) and the source is valid.
  assign accept_s    = bus.in_valid & in_ready_r;
  assign hdr_count_s = {bus.in_data, count_r[7:0]};
  assign hdr_bad_s   = (hdr_count_s == 16'd0) || ({1'b0, hdr_count_s} > DEPTH_L);

  // Next-state decode for the load sequencer.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next = HDR0;
        else       state_next = IDLE;
      end
      HDR0: begin
        if (accept_s) state_next = HDR1;
        else          state_next = HDR0;
      end
      HDR1: begin
        if (accept_s) begin
          if (hdr_bad_s) state_next = ERR;
          else           state_next = LOAD;
        end else begin
          state_next = HDR1;
        end
      end
      LOAD: begin
        if (accept_s && (pos_r == 2'd3)) state_next = WRITE;
        else                             state_next = LOAD;
      end
      WRITE: begin
        if ((index_r + 16'd1) == count_r) state_next = DONE;
        else                              state_next = LOAD;
      end
      DONE: begin
        if (start) state_next = HDR0;
        else       state_next = DONE;
      end
      ERR: begin
        if (start) state_next = HDR0;
        else       state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus status outputs registered from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      cpu_hold_r <= 1'b1;
    end else begin
      state_r    <= state_next;
      in_ready_r <= (state_next == HDR0) || (state_next == HDR1) || (state_next == LOAD);
      busy_r     <= (state_next == HDR0) || (state_next == HDR1) ||
                    (state_next == LOAD) || (state_next == WRITE);
      done_r     <= (state_next == DONE);
      error_r    <= (state_next == ERR);
      cpu_hold_r <= (state_next != DONE);
    end
  end

  // Header capture, byte assembly and instruction index tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= 16'd0;
      index_r <= 16'd0;
      pos_r   <= 2'd0;
      word_r  <= 32'd0;
    end else begin
      case (state_r)
        HDR0: begin
          if (accept_s) count_r[7:0] <= bus.in_data;
        end
        HDR1: begin
          if (accept_s) begin
            count_r[15:8] <= bus.in_data;
            index_r       <= 16'd0;
            pos_r         <= 2'd0;
            word_r        <= 32'd0;
          end
        end
        LOAD: begin
          if (accept_s) begin
            case (pos_r)
              2'd0:    word_r[7:0]   <= bus.in_data;
              2'd1:    word_r[15:8]  <= bus.in_data;
              2'd2:    word_r[23:16] <= bus.in_data;
              2'd3:    word_r[31:24] <= bus.in_data;
              default: word_r        <= word_r;
            endcase
            pos_r <= pos_r + 2'd1;
          end
        end
        WRITE: begin
          index_r <= index_r + 16'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Memory write port: strobe for the single WRITE cycle, address/data held otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'd0;
    end else if (state_next == WRITE) begin
      mem_we_r    <= 1'b1;
      mem_addr_r  <= WORDSIZE'({index_r, 2'b00});
      mem_wdata_r <= {bus.in_data, word_r[23:0]};
    end else begin
      mem_we_r    <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign cpu_hold      = cpu_hold_r;

endmodule

// File: doc/progloader.md
PROGLOADER -- requirements
Module: progloader

Interface
REQ-001 Parameter DEPTH, default 256, maximum number of 32-bit instructions the program memory holds.
REQ-002 Parameter WORDSIZE, default 64, width of mem_addr (matches core address width).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 start  input  1  load-request pulse; honoured only in IDLE, DONE, ERR.
REQ-006 in_data  input  8  incoming program byte.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both high.
REQ-009 mem_we  output  1  program-memory write strobe, one cycle per instruction.
REQ-010 mem_addr  output  WORDSIZE  byte address of the instruction written, always 4*index.
REQ-011 mem_wdata  output  32  instruction word written.
REQ-012 busy  output  1  high in HDR0, HDR1, LOAD, WRITE.
REQ-013 done  output  1  high in DONE.
REQ-014 error  output  1  high in ERR.
REQ-015 cpu_hold  output  1  high whenever the core must be held in reset; low only in DONE.

Function
REQ-016 States: IDLE, HDR0, HDR1, LOAD, WRITE, DONE, ERR; all outputs registered or decoded from state only.
REQ-017 IDLE: in_ready=0; start=1 -> HDR0 next cycle.
REQ-018 HDR0: in_ready=1; accepted byte -> count[7:0]; -> HDR1.
REQ-019 HDR1: in_ready=1; accepted byte -> count[15:8]; then count==0 or count>DEPTH -> ERR, else -> LOAD with index=0, byte position=0.
REQ-020 LOAD: in_ready=1; accepted bytes assemble little-endian: position 0 -> word[7:0] ... position 3 -> word[31:24]; position increments mod 4 per accepted byte only.
REQ-021 Fourth accepted byte -> WRITE next cycle; no byte consumed without in_valid.
REQ-022 WRITE: exactly one cycle; mem_we=1, mem_addr=4*index, mem_wdata=assembled word, in_ready=0.
REQ-023 After WRITE: index+1; index+1==count -> DONE, else -> LOAD.
REQ-024 mem_we=0 and mem_addr/mem_wdata hold last values outside WRITE.
REQ-025 Index is 16 bits; mem_addr = zero-extended index shifted left 2; no wrap possible since count<=DEPTH.
REQ-026 DONE: done=1, cpu_hold=0, in_ready=0; start=1 -> HDR0, cpu_hold=1 from that next cycle.
REQ-027 ERR: error=1, cpu_hold=1, in_ready=0, no memory writes; start=1 -> HDR0.
REQ-028 start while busy is ignored; an in_valid byte outside HDR0/HDR1/LOAD is not consumed.
REQ-029 Bytes arriving with gaps (in_valid low) stall the FSM in place with no state or counter change.
REQ-030 Latency: DONE entered 1 cycle after last WRITE; minimum load time 3 + 5*count cycles from start.

Reset
REQ-031 rst=0 at a clock edge: state IDLE, count=0, index=0, position=0, word=0, mem_addr=0, mem_wdata=0, mem_we=0, in_ready=0, busy=0, done=0, error=0, cpu_hold=1.
REQ-032 Reset mid-load discards the partial word and count; no further mem_we until a new start; already-written words are not erased.
REQ-033 Reset has priority over start and in_valid in the same cycle.

Verification
REQ-034 Start, bytes 02 00 | 13 05 80 D2 | 00 00 00 14 with in_valid held high -> mem_we at addr 0 data 0xD2800513, then addr 4 data 0x14000000; done=1, cpu_hold=0 at cycle 13 after start.
REQ-035 Header 00 00 -> ERR, error=1, cpu_hold=1, no mem_we; header with count DEPTH+1 -> same.
REQ-036 count=1, in_valid toggled every other cycle -> word assembled correctly, one mem_we, done only after 4th accepted byte.
REQ-037 rst=0 after 2 instruction bytes, then start, header 01 00, bytes AA BB CC DD -> single write addr 0 data 0xDDCCBBAA (no leftover bytes).
REQ-038 count=DEPTH full load -> last write at mem_addr 4*(DEPTH-1), DONE; start in DONE -> cpu_hold=1 next cycle, reload works.
